fp_add_align: RTL and testbench

Pipelined alignment stage for IEEE-754 floating-point addition and subtraction. It sits directly upstream of `conditional_sum_adder`. It unpacks two operands, orders them by magnitude and right-shifts the smaller mantissa with guard, round and sticky bits. It applies the two's-complement invert for effective subtraction and presents adder-ready `A`/`B`/`Cin` plus the result exponent, sign and special flags to the adder and normalization stages behind it.

---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp_unpack.sv | 35 +++
 rtl/fp_add_align.sv | 184 ++++++++++++++++++
 tb/tb_fp_add_align.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared floating-point definitions: default field widths, mantissa bus width,
// unpacked-operand record and special exponent encodings.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned MW     = FRAC_W + 5;
  localparam int unsigned OP_W   = 1 + EXP_W + FRAC_W;

  localparam logic [EXP_W-1:0] EXP_ZERO    = '0;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = '1;

  // mant uses the adder layout: headroom, hidden, fraction, G/R/S
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    mant;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp_unpacked_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpack of one packed operand into sign/exponent/mantissa and class flags.
// FP_ALIGN_DENORM_EN keeps subnormals (hidden 0, exponent 1); otherwise exponent 0 flushes to signed zero.
module fp_unpack
  import fpu_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output fp_unpacked_t    unp_o_c
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = op_i[OP_W-2 -: EXP_W];
  assign frac_f = op_i[FRAC_W-1:0];

  always_comb begin
    unp_o_c        = '0;
    unp_o_c.sign   = op_i[OP_W-1];
    unp_o_c.is_nan = (exp_f == EXP_SPECIAL) && (frac_f != '0);
    unp_o_c.is_inf = (exp_f == EXP_SPECIAL) && (frac_f == '0);
    if (exp_f == EXP_ZERO) begin
`ifdef FP_ALIGN_DENORM_EN
      unp_o_c.exp     = EXP_W'(1);
      unp_o_c.mant    = {2'b00, frac_f, 3'b000};
      unp_o_c.is_zero = (frac_f == '0);
`else
      unp_o_c.is_zero = 1'b1;
`endif
    end else begin
      unp_o_c.exp  = exp_f;
      unp_o_c.mant = {2'b01, frac_f, 3'b000};
    end
  end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage FP add/sub alignment: unpack and magnitude-order, then sticky right shift
// and subtract invert, producing adder-ready operands. Subnormals enabled by FP_ALIGN_DENORM_EN.
module fp_add_align #(
  parameter int unsigned EXP_W  = fpu_pkg::EXP_W,
  parameter int unsigned FRAC_W = fpu_pkg::FRAC_W
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+FRAC_W:0]     op_a,
  input  logic [EXP_W+FRAC_W:0]     op_b,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FRAC_W+4:0]         add_a,
  output logic [FRAC_W+4:0]         add_b,
  output logic                      add_cin,
  output logic [EXP_W-1:0]          exp_out,
  output logic                      sign_out,
  output logic                      eff_sub,
  output logic                      out_nan,
  output logic                      out_inf
);

  localparam int unsigned MW   = FRAC_W + 5;
  localparam int unsigned OP_W = 1 + EXP_W + FRAC_W;

  fpu_pkg::fp_unpacked_t ua, ub, ul, us;
  logic [OP_W-1:0] op_b_signed;
  logic            adv1, adv2, a_ge, mag_eq, eff_c;
  logic [MW-1:0]   lost_mask, shifted;

  logic             s1_valid_q, s1_valid_d;
  logic [MW-1:0]    s1_mant_l_q, s1_mant_l_d, s1_mant_s_q, s1_mant_s_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s1_dist_q, s1_dist_d;
  logic             s1_eff_q, s1_eff_d, s1_sign_q, s1_sign_d;
  logic             s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
  logic             s1_s_zero_q, s1_s_zero_d;

  logic             out_valid_q, out_valid_d;
  logic [MW-1:0]    add_a_q, add_a_d, add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  logic [EXP_W-1:0] exp_out_q, exp_out_d;
  logic             sign_q, sign_d, eff_q, eff_d, nan_q, nan_d, inf_q, inf_d;

  assign op_b_signed = {op_b[OP_W-1] ^ sub, op_b[OP_W-2:0]};

  fp_unpack u_unpack_a (.op_i(op_a),        .unp_o_c(ua));
  fp_unpack u_unpack_b (.op_i(op_b_signed), .unp_o_c(ub));

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // Magnitude order on {exp, mant}; ties keep a as the larger operand
  always_comb begin
    a_ge   = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    mag_eq = {ua.exp, ua.mant} == {ub.exp, ub.mant};
    eff_c  = ua.sign ^ ub.sign;
    ul     = a_ge ? ua : ub;
    us     = a_ge ? ub : ua;
  end

  // Sticky right shift: every bit shifted past bit 0 is ORed back into it
  always_comb begin
    lost_mask = ~({MW{1'b1}} << s1_dist_q);
    shifted   = (s1_mant_s_q >> s1_dist_q)
              | {{(MW-1){1'b0}}, |(s1_mant_s_q & lost_mask)};
    if (32'(s1_dist_q) >= MW) begin
      shifted = {{(MW-1){1'b0}}, |s1_mant_s_q};
    end
    if (s1_s_zero_q) begin
      shifted = '0;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_mant_l_d = s1_mant_l_q;
    s1_mant_s_d = s1_mant_s_q;
    s1_exp_d    = s1_exp_q;
    s1_dist_d   = s1_dist_q;
    s1_eff_d    = s1_eff_q;
    s1_sign_d   = s1_sign_q;
    s1_nan_d    = s1_nan_q;
    s1_inf_d    = s1_inf_q;
    s1_s_zero_d = s1_s_zero_q;
    out_valid_d = out_valid_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    exp_out_d   = exp_out_q;
    sign_d      = sign_q;
    eff_d       = eff_q;
    nan_d       = nan_q;
    inf_d       = inf_q;

    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mant_l_d = ul.mant;
        s1_mant_s_d = us.mant;
        s1_exp_d    = ul.exp;
        s1_dist_d   = ul.exp - us.exp;
        s1_eff_d    = eff_c;
        // exact cancellation yields +0
        s1_sign_d   = (mag_eq && eff_c) ? 1'b0 : ul.sign;
        s1_nan_d    = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && eff_c);
        s1_inf_d    = ua.is_inf || ub.is_inf;
        s1_s_zero_d = us.is_zero;
      end
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        add_a_d   = s1_mant_l_q;
        add_b_d   = s1_eff_q ? ~shifted : shifted;
        add_cin_d = s1_eff_q;
        exp_out_d = s1_exp_q;
        sign_d    = s1_sign_q;
        eff_d     = s1_eff_q;
        nan_d     = s1_nan_q;
        inf_d     = s1_inf_q && !s1_nan_q;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      s1_valid_q  <= 1'b0;
      s1_mant_l_q <= '0;
      s1_mant_s_q <= '0;
      s1_exp_q    <= '0;
      s1_dist_q   <= '0;
      s1_eff_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_s_zero_q <= 1'b0;
      out_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      exp_out_q   <= '0;
      sign_q      <= 1'b0;
      eff_q       <= 1'b0;
      nan_q       <= 1'b0;
      inf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mant_l_q <= s1_mant_l_d;
      s1_mant_s_q <= s1_mant_s_d;
      s1_exp_q    <= s1_exp_d;
      s1_dist_q   <= s1_dist_d;
      s1_eff_q    <= s1_eff_d;
      s1_sign_q   <= s1_sign_d;
      s1_nan_q    <= s1_nan_d;
      s1_inf_q    <= s1_inf_d;
      s1_s_zero_q <= s1_s_zero_d;
      out_valid_q <= out_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      exp_out_q   <= exp_out_d;
      sign_q      <= sign_d;
      eff_q       <= eff_d;
      nan_q       <= nan_d;
      inf_q       <= inf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign exp_out   = exp_out_q;
  assign sign_out  = sign_q;
  assign eff_sub   = eff_q;
  assign out_nan   = nan_q;
  assign out_inf   = inf_q;

endmodule

// File: tb/tb_fp_add_align.sv
// Bench for fp_add_align: directed vector table, backpressure and reset sequences,
// then randomized traffic scored against an arithmetic reference model.
module tb_fp_add_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic [27:0] add_a, add_b;
  logic        add_cin, sign_out, eff_sub, out_nan, out_inf;
  logic [7:0]  exp_out;

  fp_add_align dut (
    .CLOCK_50(clk), .RESET(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .exp_out(exp_out),
    .sign_out(sign_out), .eff_sub(eff_sub), .out_nan(out_nan), .out_inf(out_inf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] a;
    logic [27:0] b;
    logic        cin;
    logic [7:0]  e;
    logic        sign;
    logic        eff;
    logic        nan;
    logic        inf;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    res_t        want;
  } vec_t;

  res_t act;
  assign act = {add_a, add_b, add_cin, exp_out, sign_out, eff_sub, out_nan, out_inf};

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];
  res_t sb[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                              input logic s, input logic [27:0] ra, input logic [27:0] rb,
                              input logic cin, input logic [7:0] e, input logic sg,
                              input logic ef, input logic nn, input logic nf);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.sub = s;
    v.want = {ra, rb, cin, e, sg, ef, nn, nf};
    return v;
  endfunction

  // Reference: field decode into integers, then order, align and invert arithmetically
  function automatic void unp(input logic [31:0] x, output longint e, output longint m,
                              output bit nan, output bit inf);
    longint fe, fr;
    fe  = longint'(x[30:23]);
    fr  = longint'(x[22:0]);
    nan = (fe == 255) && (fr != 0);
    inf = (fe == 255) && (fr == 0);
    if (fe == 0) begin
`ifdef FP_ALIGN_DENORM_EN
      e = 1; m = fr * 8;
`else
      e = 0; m = 0;
`endif
    end else begin
      e = fe; m = (fr + 8388608) * 8;
    end
  endfunction

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ea, eb, ma, mb, ka, kb, el, es, ml, ms, d, sh;
    bit na, nb, ia, ib, sa, sbb, eff, a_big;
    res_t r;
    unp(a, ea, ma, na, ia);
    unp(b, eb, mb, nb, ib);
    sa  = a[31];
    sbb = b[31] ^ s;
    eff = sa ^ sbb;
    ka  = ea * 268435456 + ma;
    kb  = eb * 268435456 + mb;
    a_big = (ka >= kb);
    el = a_big ? ea : eb;  ml = a_big ? ma : mb;
    es = a_big ? eb : ea;  ms = a_big ? mb : ma;
    d  = el - es;
    if (d >= 28) sh = (ms != 0) ? 1 : 0;
    else begin
      sh = ms / (longint'(1) << d);
      if ((ms % (longint'(1) << d)) != 0) sh = sh | 1;
    end
    r.a    = 28'(ml);
    r.b    = eff ? 28'(268435455 - sh) : 28'(sh);
    r.cin  = eff;
    r.e    = 8'(el);
    r.sign = (ka == kb && eff) ? 1'b0 : (a_big ? sa : sbb);
    r.eff  = eff;
    r.nan  = na | nb | (ia & ib & eff);
    r.inf  = !r.nan && (ia | ib);
    return r;
  endfunction

  function automatic logic [31:0] rand_op(input int eb);
    logic [31:0] x;
    int k, e;
    x = $urandom;
    k = int'($urandom_range(0, 19));
    case (k)
      0: x[30:23] = 8'hFF;
      1: begin x[30:23] = 8'hFF; x[22:0] = '0; end
      2: x[30:23] = 8'h00;
      3: x[30:0] = '0;
      default: begin
        e = eb + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        x[30:23] = 8'(e);
      end
    endcase
    return x;
  endfunction

  // Called at posedge+1 with out_ready=1; checks the two-register latency
  task automatic run_vec(input vec_t v);
    op_a = v.a; op_b = v.b; sub = v.sub; in_valid = 1'b1;
    @(negedge clk);
    check({v.name, " in_ready"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({v.name, " early"}, 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    check({v.name, " valid"}, 128'(out_valid), 128'(1));
    check(v.name, 128'(act), 128'(v.want));
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    res_t e1, e2, e3, got_hold;
    logic [31:0] t1a, t2a, t3a;
    int seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; op_a = '0; op_b = '0;

    vecs.push_back(mk("1+1",        32'h3F800000, 32'h3F800000, 0, 28'h4000000, 28'h4000000, 0, 8'h7F, 0, 0, 0, 0));
    vecs.push_back(mk("1-0.5",      32'h3F800000, 32'h3F000000, 1, 28'h4000000, 28'hDFFFFFF, 1, 8'h7F, 0, 1, 0, 0));
    vecs.push_back(mk("sticky d24", 32'h4B800000, 32'h3F800001, 0, 28'h4000000, 28'h0000005, 0, 8'h97, 0, 0, 0, 0));
    vecs.push_back(mk("huge shift", 32'h7F000000, 32'h3F800000, 0, 28'h4000000, 28'h0000001, 0, 8'hFE, 0, 0, 0, 0));
    vecs.push_back(mk("inf-inf",    32'h7F800000, 32'h7F800000, 1, 28'h4000000, 28'hBFFFFFF, 1, 8'hFF, 0, 1, 1, 0));
    vecs.push_back(mk("inf+1",      32'h7F800000, 32'h3F800000, 0, 28'h4000000, 28'h0000001, 0, 8'hFF, 0, 0, 0, 1));
    vecs.push_back(mk("1-1",        32'h3F800000, 32'h3F800000, 1, 28'h4000000, 28'hBFFFFFF, 1, 8'h7F, 0, 1, 0, 0));
    vecs.push_back(mk("-2+1",       32'hC0000000, 32'h3F800000, 0, 28'h4000000, 28'hDFFFFFF, 1, 8'h80, 1, 1, 0, 0));
    vecs.push_back(mk("1-2 swap",   32'h3F800000, 32'h40000000, 1, 28'h4000000, 28'hDFFFFFF, 1, 8'h80, 1, 1, 0, 0));
    vecs.push_back(mk("nan+1",      32'h7FC00000, 32'h3F800000, 0, 28'h6000000, 28'h0000001, 0, 8'hFF, 0, 0, 1, 0));
`ifdef FP_ALIGN_DENORM_EN
    vecs.push_back(mk("denorm",     32'h00000001, 32'h00000001, 0, 28'h0000008, 28'h0000008, 0, 8'h01, 0, 0, 0, 0));
`else
    vecs.push_back(mk("denorm",     32'h00000001, 32'h00000001, 0, 28'h0000000, 28'h0000000, 0, 8'h00, 0, 0, 0, 0));
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 128'(out_valid), 128'(0));
    check("reset outputs", 128'(act), 128'(0));
    check("reset in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);
    drain();

    // Backpressure: two accepted, third stalls, outputs frozen, then 1/cycle in order
    t1a = 32'h40400000; t2a = 32'h40A00000; t3a = 32'h41100000;
    e1 = model(t1a, 32'h3F800000, 0);
    e2 = model(t2a, 32'h3F800000, 1);
    e3 = model(t3a, 32'h3E800000, 0);
    out_ready = 1'b0;
    op_a = t1a; op_b = 32'h3F800000; sub = 0; in_valid = 1'b1;
    @(negedge clk); check("bp accept 1", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    op_a = t2a; op_b = 32'h3F800000; sub = 1;
    @(negedge clk); check("bp accept 2", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    op_a = t3a; op_b = 32'h3E800000; sub = 0;
    @(negedge clk);
    check("bp third stalled", 128'(in_ready), 128'(0));
    check("bp head valid", 128'(out_valid), 128'(1));
    check("bp head data", 128'(act), 128'(e1));
    got_hold = act;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("bp hold ready", 128'(in_ready), 128'(0));
      check("bp hold valid", 128'(out_valid), 128'(1));
      check("bp hold stable", 128'(act), 128'(got_hold));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp out1 data", 128'(act), 128'(e1));
    check("bp third accept", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp out2 valid", 128'(out_valid), 128'(1));
    check("bp out2 data", 128'(act), 128'(e2));
    @(posedge clk); @(negedge clk);
    check("bp out3 valid", 128'(out_valid), 128'(1));
    check("bp out3 data", 128'(act), 128'(e3));
    @(posedge clk); @(negedge clk);
    check("bp empty", 128'(out_valid), 128'(0));
    @(posedge clk); #1;

    // Reset with two transactions in flight
    out_ready = 1'b0;
    op_a = 32'h3F800000; op_b = 32'h3F800000; sub = 0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre-reset valid", 128'(out_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("mid reset valid", 128'(out_valid), 128'(0));
    check("mid reset outputs", 128'(act), 128'(0));
    check("mid reset in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post reset no emit", 128'(seen), 128'(0));
    @(posedge clk); #1;

    // Randomized traffic with scoreboard
    for (int c = 0; c < 600; c++) begin
      int eb;
      eb = int'($urandom_range(1, 254));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      sub       = $urandom_range(0, 1);
      op_a      = rand_op(eb);
      if ($urandom_range(0, 7) == 0) op_b = {1'($urandom_range(0, 1)), op_a[30:0]};
      else                           op_b = rand_op(eb);
      @(negedge clk);
      if (in_valid && in_ready) sb.push_back(model(op_a, op_b, sub));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rand spurious output", 128'(1), 128'(0));
        else check("rand", 128'(act), 128'(sb.pop_front()));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) check("rand drain", 128'(act), 128'(sb.pop_front()));
      @(posedge clk); #1;
    end
    check("rand drain empty", 128'(sb.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
